// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, bit positions and init ROM for the HD44780 controller
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_state_e;

    localparam int LCD_DATA_LSB = 0;
    localparam int LCD_RS_BIT   = 8;
    localparam int LCD_REQ_BIT  = 9;
    localparam int LCD_ON_BIT   = 31;

    localparam logic [1:0] WSEL_CMD   = 2'd0;
    localparam logic [1:0] WSEL_LONG  = 2'd1;
    localparam logic [1:0] WSEL_INIT1 = 2'd2;
    localparam logic [1:0] WSEL_INIT2 = 2'd3;

    localparam int INIT_LEN = 7;

    // Each entry is {command, post-write wait selector}; index 0 runs first.
    localparam logic [0:INIT_LEN-1][9:0] INIT_ROM = {
        {8'h38, WSEL_INIT1},
        {8'h38, WSEL_INIT2},
        {8'h38, WSEL_CMD},
        {8'h38, WSEL_CMD},
        {8'h0C, WSEL_CMD},
        {8'h01, WSEL_LONG},
        {8'h06, WSEL_CMD}
    };

    // Clear display (0x01) and return home (0x02/0x03) need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
    endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// rtl/lcd_hd44780_ctrl_if.sv - LCD pin bundle driven by the controller
interface lcd_hd44780_ctrl_if;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;

    modport master (output lcd_data, output lcd_rs, output lcd_rw, output lcd_en, output lcd_on);
    modport slave  (input  lcd_data, input  lcd_rs, input  lcd_rw, input  lcd_en, input  lcd_on);
endinterface

// File: rtl/lcd_delay_timer.sv
// rtl/lcd_delay_timer.sv - loadable 20-bit down counter; done pulses in the last cycle of the load
module lcd_delay_timer (
    input  logic        i_clk,
    input  logic        i_load,
    input  logic [19:0] i_value,
    output logic        o_done
);
    logic [19:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_cnt <= (i_value == 20'd0) ? 20'd1 : i_value;
        end else if (r_cnt != 20'd0) begin
            r_cnt <= r_cnt - 20'd1;
        end
    end

    assign o_done = (r_cnt == 20'd1);
endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - HD44780 write-only controller with automatic power-on init
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_LONG  = 100000,
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_INIT1 = 205000,
    parameter int unsigned T_INIT2 = 5000
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [31:0]                i_lcd_word,
    lcd_hd44780_ctrl_if.master         lcd_bus,
    output logic                       o_busy,
    output logic                       o_init_done,
    output logic                       o_overrun
);
    lcd_state_e  r_state, w_next;
    logic [2:0]  r_init_idx;
    logic [7:0]  r_lcd_data;
    logic        r_lcd_rs, r_lcd_en, r_lcd_on;
    logic        r_init_done, r_overrun;
    logic        r_req_q;
    logic        r_pend_valid, r_pend_rs;
    logic [7:0]  r_pend_data;
    logic        w_req, w_pop, w_done, w_load;
    logic [19:0] w_load_val, w_wait_val;
    logic [9:0]  w_rom_entry;
    logic        w_unused;

    assign w_unused    = ^i_lcd_word[30:10];
    assign w_rom_entry = INIT_ROM[r_init_idx];
    assign w_req       = i_lcd_word[LCD_REQ_BIT] != r_req_q;
    assign w_pop       = (r_state == IDLE) && r_pend_valid;

    lcd_delay_timer u_timer (
        .i_clk   (i_clk),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_done  (w_done)
    );

    always_comb begin
        w_wait_val = 20'(T_CMD);
        if (!r_init_done) begin
            case (w_rom_entry[1:0])
                WSEL_LONG:  w_wait_val = 20'(T_LONG);
                WSEL_INIT1: w_wait_val = 20'(T_INIT1);
                WSEL_INIT2: w_wait_val = 20'(T_INIT2);
                default:    w_wait_val = 20'(T_CMD);
            endcase
        end else if (is_long_cmd(r_lcd_rs, r_lcd_data)) begin
            w_wait_val = 20'(T_LONG);
        end
    end

    // The timer is reloaded on every state entry; reset itself loads the power-up delay.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = 20'd0;
        if (i_reset) begin
            w_load     = 1'b1;
            w_load_val = 20'(T_PWRUP);
        end else begin
            case (r_state)
                PWRUP: if (w_done) w_next = INIT;
                INIT: begin
                    w_next     = SETUP;
                    w_load     = 1'b1;
                    w_load_val = 20'(T_SETUP);
                end
                IDLE: if (r_pend_valid) begin
                    w_next     = SETUP;
                    w_load     = 1'b1;
                    w_load_val = 20'(T_SETUP);
                end
                SETUP: if (w_done) begin
                    w_next     = PULSE;
                    w_load     = 1'b1;
                    w_load_val = 20'(T_EN);
                end
                PULSE: if (w_done) begin
                    w_next     = HOLD;
                    w_load     = 1'b1;
                    w_load_val = 20'(T_HOLD);
                end
                HOLD: if (w_done) begin
                    w_next     = WAIT;
                    w_load     = 1'b1;
                    w_load_val = w_wait_val;
                end
                WAIT: if (w_done) begin
                    w_next = (!r_init_done && r_init_idx != 3'(INIT_LEN - 1)) ? INIT : IDLE;
                end
                default: w_next = PWRUP;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        r_req_q <= i_lcd_word[LCD_REQ_BIT];
        if (i_reset) begin
            r_state      <= PWRUP;
            r_init_idx   <= 3'd0;
            r_lcd_data   <= 8'd0;
            r_lcd_rs     <= 1'b0;
            r_lcd_en     <= 1'b0;
            r_lcd_on     <= 1'b0;
            r_init_done  <= 1'b0;
            r_overrun    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_rs    <= 1'b0;
            r_pend_data  <= 8'd0;
        end else begin
            r_state  <= w_next;
            r_lcd_en <= (w_next == PULSE);
            r_lcd_on <= i_lcd_word[LCD_ON_BIT];
            if (r_state == INIT) begin
                r_lcd_data <= w_rom_entry[9:2];
                r_lcd_rs   <= 1'b0;
            end else if (w_pop) begin
                r_lcd_data <= r_pend_data;
                r_lcd_rs   <= r_pend_rs;
            end
            if (r_state == WAIT && w_done && !r_init_done) begin
                if (r_init_idx == 3'(INIT_LEN - 1)) r_init_done <= 1'b1;
                else r_init_idx <= r_init_idx + 3'd1;
            end
            // A pop in the same cycle frees the slot for the incoming request.
            if (w_req) begin
                if (!r_pend_valid || w_pop) begin
                    r_pend_valid <= 1'b1;
                    r_pend_rs    <= i_lcd_word[LCD_RS_BIT];
                    r_pend_data  <= i_lcd_word[LCD_DATA_LSB +: 8];
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_pop) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign lcd_bus.lcd_data = r_lcd_data;
    assign lcd_bus.lcd_rs   = r_lcd_rs;
    assign lcd_bus.lcd_rw   = 1'b0;
    assign lcd_bus.lcd_en   = r_lcd_en;
    assign lcd_bus.lcd_on   = r_lcd_on;
    assign o_busy           = (r_state != IDLE) || r_pend_valid;
    assign o_init_done      = r_init_done;
    assign o_overrun        = r_overrun;
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb/tb_lcd_hd44780_ctrl.sv - self-checking bench for lcd_hd44780_ctrl
module tb_lcd_hd44780_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lcd_word;
    logic        busy, init_done, overrun;
    int          checks = 0;
    int          errors = 0;
    int          p_data[$];
    int          p_rs[$];
    int          p_w[$];
    int          p_st[$];

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         exp_tail;
        string      name;
    } vec_t;

    vec_t vecs[8];
    int   exp_init[7];

    always #5 clk = ~clk;

    lcd_hd44780_ctrl_if bus ();

    lcd_hd44780_ctrl #(
        .T_SETUP(1), .T_EN(3), .T_HOLD(1), .T_CMD(5),
        .T_LONG(20), .T_PWRUP(10), .T_INIT1(8), .T_INIT2(6)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_lcd_word  (lcd_word),
        .lcd_bus     (bus),
        .o_busy      (busy),
        .o_init_done (init_done),
        .o_overrun   (overrun)
    );

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_until_idle(input int budget);
        logic prev_en;
        int   w, d, r, st;
        bit   finished;
        prev_en = 1'b0;
        w = 0; d = 0; r = 0; st = 1;
        finished = 1'b0;
        p_data.delete(); p_rs.delete(); p_w.delete(); p_st.delete();
        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge clk);
            if (bus.lcd_en) begin
                if (!prev_en) begin
                    d = int'(bus.lcd_data); r = int'(bus.lcd_rs); w = 0; st = 1;
                end
                w++;
                if (d != int'(bus.lcd_data) || r != int'(bus.lcd_rs)) st = 0;
            end else if (prev_en) begin
                if (d != int'(bus.lcd_data) || r != int'(bus.lcd_rs)) st = 0;
                p_data.push_back(d); p_rs.push_back(r); p_w.push_back(w); p_st.push_back(st);
            end
            prev_en = bus.lcd_en;
            if (!busy && !bus.lcd_en) finished = 1'b1;
        end
        check_eq("idle_reached", int'(finished), 1);
    endtask

    task automatic do_vec(input vec_t v);
        int lat, w, tail, d, r, st;
        lcd_word[9]   = ~lcd_word[9];
        lcd_word[8]   = v.rs;
        lcd_word[7:0] = v.data;
        @(negedge clk);
        check_eq({v.name, "_busy_after_req"}, int'(busy), 1);
        lat = 1;
        while (!bus.lcd_en && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq({v.name, "_en_latency"}, lat, 3);
        d = int'(bus.lcd_data); r = int'(bus.lcd_rs); w = 0; st = 1;
        while (bus.lcd_en && w < 50) begin
            w++;
            if (d != int'(bus.lcd_data) || r != int'(bus.lcd_rs)) st = 0;
            @(negedge clk);
        end
        if (d != int'(bus.lcd_data) || r != int'(bus.lcd_rs)) st = 0;
        tail = 0;
        while (busy && tail < 100) begin
            tail++;
            @(negedge clk);
        end
        check_eq({v.name, "_data"}, d, int'(v.data));
        check_eq({v.name, "_rs"}, r, int'(v.rs));
        check_eq({v.name, "_en_width"}, w, 3);
        check_eq({v.name, "_stable"}, st, 1);
        check_eq({v.name, "_hold_plus_wait"}, tail, v.exp_tail);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        vecs[0] = '{1'b1, 8'h41, 6,  "char_41"};
        vecs[1] = '{1'b0, 8'h01, 21, "clear_01"};
        vecs[2] = '{1'b0, 8'h80, 6,  "ddram_80"};
        vecs[3] = '{1'b0, 8'h02, 21, "home_02"};
        vecs[4] = '{1'b0, 8'h03, 21, "home_03"};
        vecs[5] = '{1'b0, 8'h04, 6,  "entry_04"};
        vecs[6] = '{1'b1, 8'h01, 6,  "rs1_01"};
        vecs[7] = '{1'b0, 8'h00, 6,  "nop_00"};
        exp_init = '{'h38, 'h38, 'h38, 'h38, 'h0C, 'h01, 'h06};

        rst      = 1'b1;
        lcd_word = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_en", int'(bus.lcd_en), 0);
        check_eq("rst_data", int'(bus.lcd_data), 0);
        check_eq("rst_rs", int'(bus.lcd_rs), 0);
        check_eq("rst_rw", int'(bus.lcd_rw), 0);
        check_eq("rst_on", int'(bus.lcd_on), 0);
        check_eq("rst_init_done", int'(init_done), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        check_eq("rst_busy", int'(busy), 1);
        lcd_word[31] = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_until_idle(500);
        check_eq("init_pulse_count", p_data.size(), 7);
        for (int i = 0; i < 7 && i < p_data.size(); i++) begin
            check_eq($sformatf("init%0d_data", i), p_data[i], exp_init[i]);
            check_eq($sformatf("init%0d_rs", i), p_rs[i], 0);
            check_eq($sformatf("init%0d_width", i), p_w[i], 3);
        end
        check_eq("init_done_set", int'(init_done), 1);
        check_eq("busy_after_init", int'(busy), 0);
        check_eq("lcd_on_follows", int'(bus.lcd_on), 1);

        foreach (vecs[i]) do_vec(vecs[i]);
        check_eq("no_overrun_yet", int'(overrun), 0);

        for (int k = 0; k < 3; k++) begin
            lcd_word[9]   = ~lcd_word[9];
            lcd_word[8]   = 1'b1;
            lcd_word[7:0] = 8'(8'hA1 + k);
            @(negedge clk);
        end
        run_until_idle(300);
        check_eq("ovr_pulse_count", p_data.size(), 2);
        if (p_data.size() >= 2) begin
            check_eq("ovr_first", p_data[0], 'hA1);
            check_eq("ovr_second", p_data[1], 'hA2);
        end
        check_eq("overrun_set", int'(overrun), 1);

        lcd_word[9] = ~lcd_word[9]; lcd_word[7:0] = 8'h11;
        @(negedge clk);
        lcd_word[9] = ~lcd_word[9]; lcd_word[7:0] = 8'h22;
        @(negedge clk);
        for (int c = 0; c < 20 && !bus.lcd_en; c++) @(negedge clk);
        check_eq("en_before_reset", int'(bus.lcd_en), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_en", int'(bus.lcd_en), 0);
        check_eq("rst_mid_init_done", int'(init_done), 0);
        check_eq("rst_mid_overrun", int'(overrun), 0);
        check_eq("rst_mid_data", int'(bus.lcd_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        lcd_word[9]   = ~lcd_word[9];
        lcd_word[8]   = 1'b1;
        lcd_word[7:0] = 8'h5A;
        run_until_idle(600);
        check_eq("pwrup_req_pulse_count", p_data.size(), 8);
        if (p_data.size() >= 8) begin
            check_eq("pwrup_last_init", p_data[6], 'h06);
            check_eq("pwrup_req_data", p_data[7], 'h5A);
            check_eq("pwrup_req_rs", p_rs[7], 1);
            check_eq("pwrup_req_stable", p_st[7], 1);
        end
        check_eq("reinit_done", int'(init_done), 1);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.lcd_en) extra++;
        end
        check_eq("no_spurious_write", extra, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
